// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit positions and forwarding encodings.
package pipe_pkg;

    // Width of the opaque control bundle carried down the pipe
    localparam int unsigned CW = 8;

    // Fixed bit positions inside the control bundle
    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_MEMWRITE = 2;

    // Operand source selects for the execute-stage muxes
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one source operand: MEM result beats WB data, $0 never forwards.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [4:0] src,
    input  logic       mem_regwrite,
    input  logic [4:0] mem_wa,
    input  logic       wb_regwrite,
    input  logic [4:0] wb_wa,
    output logic [1:0] sel
);

    // Pick the youngest in-flight producer of src
    always_comb begin
        sel = FWD_REG;
        if (mem_regwrite && (mem_wa != 5'd0) && (mem_wa == src)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_wa != 5'd0) && (wb_wa == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, held-operand refresh and
// execute-stage forwarding selects.
module idex_stage #(
    parameter int unsigned DW  = 32,
    parameter int unsigned CW  = pipe_pkg::CW,
    parameter int unsigned SCW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           id_valid,
    input  logic [4:0]     id_rs,
    input  logic [4:0]     id_rt,
    input  logic [4:0]     id_wa,
    input  logic [DW-1:0]  id_rd1,
    input  logic [DW-1:0]  id_rd2,
    input  logic [DW-1:0]  id_imm,
    input  logic [CW-1:0]  id_ctrl,
    input  logic           ex_hold,
    input  logic           flush,
    input  logic           mem_regwrite,
    input  logic [4:0]     mem_wa,
    input  logic           wb_regwrite,
    input  logic [4:0]     wb_wa,
    input  logic [DW-1:0]  wb_wd,
    output logic           stall_id,
    output logic           ex_valid,
    output logic [4:0]     ex_rs,
    output logic [4:0]     ex_rt,
    output logic [4:0]     ex_wa,
    output logic [DW-1:0]  ex_a,
    output logic [DW-1:0]  ex_b,
    output logic [DW-1:0]  ex_imm,
    output logic [CW-1:0]  ex_ctrl,
    output logic [1:0]     ex_fwd_a,
    output logic [1:0]     ex_fwd_b,
    output logic [SCW-1:0] stall_cnt
);

    import pipe_pkg::CTRL_MEMTOREG;

    logic lu;
    logic wb_hit_a;
    logic wb_hit_b;

    // Hazard detection and writeback-refresh matches on the registered EX tags
    always_comb begin
        lu = id_valid && ex_valid && ex_ctrl[CTRL_MEMTOREG] && (ex_wa != 5'd0)
             && ((ex_wa == id_rs) || (ex_wa == id_rt));
        stall_id = lu || ex_hold;
        wb_hit_a = wb_regwrite && (wb_wa != 5'd0) && (wb_wa == ex_rs);
        wb_hit_b = wb_regwrite && (wb_wa != 5'd0) && (wb_wa == ex_rt);
    end

    // EX slot update: hold > flush > load-use bubble > normal load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_wa     <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_imm    <= '0;
            ex_ctrl   <= '0;
            stall_cnt <= '0;
        end else if (ex_hold) begin
            // Keep held operands current with results retiring underneath them
            if (wb_hit_a) ex_a <= wb_wd;
            if (wb_hit_b) ex_b <= wb_wd;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (lu) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            if (stall_cnt != {SCW{1'b1}}) stall_cnt <= stall_cnt + SCW'(1);
        end else begin
            ex_valid <= id_valid;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_wa    <= id_wa;
            ex_a     <= id_rd1;
            ex_b     <= id_rd2;
            ex_imm   <= id_imm;
            ex_ctrl  <= id_valid ? id_ctrl : '0;
        end
    end

    fwd_sel u_fwd_a (
        .src          (ex_rs),
        .mem_regwrite (mem_regwrite),
        .mem_wa       (mem_wa),
        .wb_regwrite  (wb_regwrite),
        .wb_wa        (wb_wa),
        .sel          (ex_fwd_a)
    );

    fwd_sel u_fwd_b (
        .src          (ex_rt),
        .mem_regwrite (mem_regwrite),
        .mem_wa       (mem_wa),
        .wb_regwrite  (wb_regwrite),
        .wb_wa        (wb_wa),
        .sel          (ex_fwd_b)
    );

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage; the stall counter is narrowed so saturation is reachable.
module tb_idex_stage;

    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 8;
    localparam int unsigned SCW = 4;

    localparam logic [CW-1:0] C_ALU  = 8'h01;  // regwrite
    localparam logic [CW-1:0] C_LOAD = 8'h03;  // regwrite + memtoreg

    logic           clk = 1'b0;
    logic           reset;
    logic           id_valid;
    logic [4:0]     id_rs, id_rt, id_wa;
    logic [DW-1:0]  id_rd1, id_rd2, id_imm;
    logic [CW-1:0]  id_ctrl;
    logic           ex_hold, flush;
    logic           mem_regwrite;
    logic [4:0]     mem_wa;
    logic           wb_regwrite;
    logic [4:0]     wb_wa;
    logic [DW-1:0]  wb_wd;
    logic           stall_id, ex_valid;
    logic [4:0]     ex_rs, ex_rt, ex_wa;
    logic [DW-1:0]  ex_a, ex_b, ex_imm;
    logic [CW-1:0]  ex_ctrl;
    logic [1:0]     ex_fwd_a, ex_fwd_b;
    logic [SCW-1:0] stall_cnt;

    int n_chk = 0;
    int n_fail = 0;

    idex_stage #(
        .DW  (DW),
        .CW  (CW),
        .SCW (SCW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_wa        (id_wa),
        .id_rd1       (id_rd1),
        .id_rd2       (id_rd2),
        .id_imm       (id_imm),
        .id_ctrl      (id_ctrl),
        .ex_hold      (ex_hold),
        .flush        (flush),
        .mem_regwrite (mem_regwrite),
        .mem_wa       (mem_wa),
        .wb_regwrite  (wb_regwrite),
        .wb_wa        (wb_wa),
        .wb_wd        (wb_wd),
        .stall_id     (stall_id),
        .ex_valid     (ex_valid),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_wa        (ex_wa),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_imm       (ex_imm),
        .ex_ctrl      (ex_ctrl),
        .ex_fwd_a     (ex_fwd_a),
        .ex_fwd_b     (ex_fwd_b),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] wa, input logic [DW-1:0] rd1,
                          input logic [DW-1:0] rd2, input logic [DW-1:0] imm,
                          input logic [CW-1:0] ctrl);
        id_valid = v;
        id_rs    = rs;
        id_rt    = rt;
        id_wa    = wa;
        id_rd1   = rd1;
        id_rd2   = rd2;
        id_imm   = imm;
        id_ctrl  = ctrl;
    endtask

    initial begin
        reset = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0);
        ex_hold = 1'b0; flush = 1'b0;
        mem_regwrite = 1'b0; mem_wa = 5'd0;
        wb_regwrite = 1'b0; wb_wa = 5'd0; wb_wd = '0;
        #2;
        // Reset state
        chk("rst_valid", ex_valid, 0);
        chk("rst_ctrl", ex_ctrl, 0);
        chk("rst_a", ex_a, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_fwd_a", ex_fwd_a, 0);
        chk("rst_stall", stall_id, 0);
        ex_hold = 1'b1; #1;
        chk("rst_stall_hold", stall_id, 1);
        ex_hold = 1'b0;
        tick();
        reset = 1'b0;

        // add $3,$1,$2 then sub $4,$3,$5
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 32'd0, C_ALU);
        tick();
        chk("add_valid", ex_valid, 1);
        chk("add_wa", ex_wa, 3);
        chk("add_a", ex_a, 10);
        chk("add_b", ex_b, 20);
        chk("add_ctrl", ex_ctrl, C_ALU);
        set_id(1'b1, 5'd3, 5'd5, 5'd4, 32'd0, 32'd50, 32'd0, C_ALU);
        #1;
        chk("sub_no_stall", stall_id, 0);
        tick();
        mem_regwrite = 1'b1; mem_wa = 5'd3;
        #1;
        chk("sub_fwd_a_mem", ex_fwd_a, 2'b10);
        chk("sub_fwd_b_none", ex_fwd_b, 2'b00);
        chk("sub_stall", stall_id, 0);
        wb_regwrite = 1'b1; wb_wa = 5'd5;
        #1;
        chk("sub_fwd_b_wb", ex_fwd_b, 2'b01);
        wb_wa = 5'd3;
        #1;
        chk("mem_beats_wb", ex_fwd_a, 2'b10);
        mem_regwrite = 1'b0;
        #1;
        chk("wb_only_a", ex_fwd_a, 2'b01);
        wb_regwrite = 1'b0; mem_wa = 5'd0; wb_wa = 5'd0;

        // Load-use: lw $3 then a reader of $3
        set_id(1'b1, 5'd1, 5'd9, 5'd3, 32'd0, 32'd0, 32'd4, C_LOAD);
        tick();
        set_id(1'b1, 5'd3, 5'd6, 5'd7, 32'd1, 32'd2, 32'd0, C_ALU);
        #1;
        chk("lu_stall", stall_id, 1);
        tick();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_ctrl", ex_ctrl, 0);
        chk("lu_cnt", stall_cnt, 1);
        chk("lu_stall_once", stall_id, 0);
        tick();
        chk("lu_after_valid", ex_valid, 1);
        chk("lu_after_wa", ex_wa, 7);

        // Load to $0 followed by a read of $0
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 32'd0, C_LOAD);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, C_ALU);
        #1;
        chk("r0_no_stall", stall_id, 0);
        tick();
        mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        #1;
        chk("r0_fwd_a", ex_fwd_a, 2'b00);
        chk("r0_cnt", stall_cnt, 1);
        mem_regwrite = 1'b0; wb_regwrite = 1'b0;

        // Hold 3 cycles with WB writing $7 = ex_rt; flush during hold is ignored
        set_id(1'b1, 5'd4, 5'd7, 5'd8, 32'h11, 32'h22, 32'h33, C_ALU);
        tick();
        ex_hold = 1'b1; flush = 1'b1;
        wb_regwrite = 1'b1; wb_wa = 5'd7; wb_wd = 32'hDEADBEEF;
        set_id(1'b1, 5'd9, 5'd10, 5'd11, 32'h99, 32'h98, 32'h97, C_LOAD);
        #1;
        chk("hold_stall", stall_id, 1);
        chk("hold_fwd_b_wb", ex_fwd_b, 2'b01);
        tick(); tick(); tick();
        ex_hold = 1'b0; flush = 1'b0; wb_regwrite = 1'b0; wb_wa = 5'd0;
        #1;
        chk("hold_b", ex_b, 32'hDEADBEEF);
        chk("hold_a", ex_a, 32'h11);
        chk("hold_rs", ex_rs, 4);
        chk("hold_wa", ex_wa, 8);
        chk("hold_imm", ex_imm, 32'h33);
        chk("hold_valid", ex_valid, 1);
        chk("hold_ctrl", ex_ctrl, C_ALU);

        // Flush and load-use on the same edge: flush wins, nothing counted
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 32'd0, 32'd0, 32'd0, C_LOAD);
        tick();
        set_id(1'b1, 5'd5, 5'd2, 5'd6, 32'd0, 32'd0, 32'd0, C_ALU);
        flush = 1'b1;
        #1;
        chk("fl_lu_stall", stall_id, 1);
        tick();
        flush = 1'b0;
        chk("fl_lu_valid", ex_valid, 0);
        chk("fl_lu_cnt", stall_cnt, 1);

        // Saturation: counter is at 1; 14 more events reach all-ones
        for (int i = 0; i < 21; i++) begin
            set_id(1'b1, 5'd1, 5'd2, 5'd5, 32'd0, 32'd0, 32'd0, C_LOAD);
            tick();
            set_id(1'b1, 5'd5, 5'd2, 5'd6, 32'd0, 32'd0, 32'd0, C_ALU);
            tick();
            if (i == 13) chk("sat_reach", stall_cnt, 4'hF);
        end
        chk("sat_hold", stall_cnt, 4'hF);

        // Reset asserted mid-stall clears everything immediately
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 32'h1234, 32'h5678, 32'h9, C_LOAD);
        tick();
        set_id(1'b1, 5'd5, 5'd2, 5'd6, 32'd0, 32'd0, 32'd0, C_ALU);
        #1;
        chk("pre_rst_stall", stall_id, 1);
        reset = 1'b1;
        #1;
        chk("arst_valid", ex_valid, 0);
        chk("arst_cnt", stall_cnt, 0);
        chk("arst_a", ex_a, 0);
        chk("arst_wa", ex_wa, 0);
        chk("arst_ctrl", ex_ctrl, 0);
        chk("arst_stall", stall_id, 0);
        tick();
        reset = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0);
        tick();
        chk("post_rst_valid", ex_valid, 0);
        chk("post_rst_cnt", stall_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/idex_stage.md
# idex_stage

Decode-to-execute pipeline register for the 5-stage MIPS core, sitting directly downstream of the register file. It latches the two register-file read operands, immediate, destination and control bits each cycle and detects load-use hazards, stalling decode and injecting a bubble. It also refreshes held operands on writeback while execute is stalled, and produces the execute-stage forwarding selects from the MEM and WB destination tags.

## Interface
- `DW`, 32: datapath width (operands, immediate, writeback data).
- `CW`, 8: opaque control bundle width; fields at fixed bit positions defined in the package.
- `SCW`, 16: stall-counter width.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `id_valid` in 1: decode slot holds a real instruction.
- `id_rs`, `id_rt` in 5: source register numbers (the register-file `ra1`/`ra2`).
- `id_wa` in 5: destination register chosen by decode.
- `id_rd1`, `id_rd2` in DW: register-file read data (already WB-bypassed).
- `id_imm` in DW: sign/zero-extended immediate.
- `id_ctrl` in CW: control bundle; bit `CTRL_REGWRITE`, bit `CTRL_MEMTOREG` (load).
- `ex_hold` in 1: downstream cannot accept; freeze EX contents.
- `flush` in 1: taken branch/jump resolved; kill the instruction entering EX.
- `mem_regwrite` in 1, `mem_wa` in 5: MEM-stage destination tag.
- `wb_regwrite` in 1, `wb_wa` in 5, `wb_wd` in DW: WB write port (same as register-file `we3`/`wa3`/`wd3`).
- `stall_id` out 1: hold PC and IF/ID this cycle (combinational).
- `ex_valid` out 1, `ex_rs`/`ex_rt`/`ex_wa` out 5, `ex_a`/`ex_b`/`ex_imm` out DW, `ex_ctrl` out CW: registered EX slot.
- `ex_fwd_a`, `ex_fwd_b` out 2: operand source select: 00 = `ex_a`/`ex_b`, 01 = WB data, 10 = MEM result.
- `stall_cnt` out SCW: count of load-use bubbles inserted, saturating.

## Operation
- Load-use hazard `lu = id_valid & ex_valid & ex_ctrl[CTRL_MEMTOREG] & (ex_wa != 0) & (ex_wa == id_rs | ex_wa == id_rt)`.
- `stall_id = lu | ex_hold`.
- Per-edge priority, highest first:
  1. `reset`: all registers cleared.
  2. `ex_hold`: EX slot frozen, except `ex_a`/`ex_b` are refreshed with `wb_wd` when `wb_regwrite & wb_wa != 0 & wb_wa == ex_rs`/`ex_rt` (held operand stays current). `flush` is ignored while held; upstream re-asserts it.
  3. `flush`: `ex_valid <= 0`; other fields don't-care.
  4. `lu`: `ex_valid <= 0` (bubble); `stall_cnt` increments, saturating at all-ones.
  5. Otherwise load all `id_*` into `ex_*`; `ex_valid <= id_valid`.
- A bubble forces its effective control to zero: `ex_ctrl` is loaded as 0 whenever `ex_valid` is loaded 0.
- Forwarding, combinational on registered tags:
  - `ex_fwd_a = 10` if `mem_regwrite & mem_wa != 0 & mem_wa == ex_rs`;
  - else `01` if the same test holds with `wb_*`;
  - else `00`. `ex_fwd_b` uses `ex_rt` the same way. MEM wins over WB.
- Register 0 is never forwarded or refreshed; it always reads as the latched value (0 from the register file).

## Timing
- Latency: one cycle from ID to EX outputs.
- `stall_id` and `ex_fwd_*` are same-cycle combinational; no edge delay.
- Reset values: `ex_valid` = 0, `ex_ctrl` = 0, all tags/data = 0, `stall_cnt` = 0. Hence `ex_fwd_*` = 00 and `stall_id` = `ex_hold` after reset.
- Reset asserted mid-hold or mid-stall: the slot is empty from the next cycle; no bubble is counted.
- `lu` lasts exactly one cycle per load, because the bubble clears `ex_valid`.
- Simultaneous `flush` + `lu`: `flush` wins; no bubble is counted.

## Structure
- Package `pipe_pkg`: `CTRL_REGWRITE`, `CTRL_MEMTOREG`, `CTRL_MEMWRITE` bit indices, `CW`, and the `FWD_REG`/`FWD_WB`/`FWD_MEM` 2-bit encodings.
- One sub-module, `fwd_sel`: one instance per operand, mapping (src tag, mem tag/we, wb tag/we) to a 2-bit select. It is reused later by the EX/MEM store-data path.

## Test plan
- Back-to-back ALU ops, `add $3,$1,$2` then `sub $4,$3,$5` → at the second op in EX, `ex_fwd_a` = 10, `stall_id` = 0.
- Load-use: `lw $3` in EX, `id_rs` = 3 → `stall_id` = 1 for one cycle, next `ex_valid` = 0, `stall_cnt` 0 → 1.
- Load to $0 followed by a read of $0 → no stall, `ex_fwd_a` = 00.
- `ex_hold` for 3 cycles with `wb_wa` = `ex_rt` = 7 and `wb_wd` = 0xDEADBEEF → after hold, `ex_b` = 0xDEADBEEF and other fields unchanged.
- `flush` and `lu` in the same cycle → `ex_valid` = 0, `stall_cnt` unchanged.
- 2^16 + 5 load-use events → `stall_cnt` = 0xFFFF; assert `reset` mid-stall → all outputs return to 0 asynchronously.
